// File: rtl/fd_pkg.sv
// fd_pkg: shared types and constants for the fetch/decode controller.
package fd_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, DECODE, EXEC, HALT} state_e;
    localparam int OP_W     = 4;
    localparam int REG_W    = 2;
    localparam int REG1_LSB = 10;
    localparam int REG2_LSB = 8;
    localparam int DEST_LSB = 6;
    localparam int IMM1_W   = 6;
    localparam int IMM2_W   = 8;
    localparam int IMM3_W   = 10;
    localparam int ACC_IDX  = 0;
    localparam int ACCO_IDX = 1;
    localparam int SP_IDX   = 2;
    localparam int RA_IDX   = 3;
    localparam logic [OP_W-1:0] HALT_OP_DEF = 4'hF;
endpackage

// File: rtl/fd_regfile.sv
// fd_regfile: NREG x DATA_W register file, one write port, two combinational
// read ports and fixed taps for the architectural registers.
module fd_regfile
    import fd_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 4,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_a_i,
    input  logic [AW-1:0]     rd_addr_b_i,
    output logic [DATA_W-1:0] rd_data_a_o,
    output logic [DATA_W-1:0] rd_data_b_o,
    output logic [DATA_W-1:0] acc_o,
    output logic [DATA_W-1:0] acco_o,
    output logic [DATA_W-1:0] sp_o,
    output logic [DATA_W-1:0] ra_o
);
    logic [DATA_W-1:0] regs_q [NREG];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            regs_q <= '{default: '0};
        else if (wr_en_i)
            regs_q[wr_addr_i] <= wr_data_i;
    end

    // reads see the stored value only; a same-cycle write is not forwarded
    assign rd_data_a_o = regs_q[rd_addr_a_i];
    assign rd_data_b_o = regs_q[rd_addr_b_i];
    assign acc_o       = regs_q[ACC_IDX];
    assign acco_o      = regs_q[ACCO_IDX];
    assign sp_o        = regs_q[SP_IDX];
    assign ra_o        = regs_q[RA_IDX];
endmodule

// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl: self-running fetch/wait/decode/execute sequencer owning
// the PC, instruction register, field decode and architectural register file.
module fetch_decode_ctrl
    import fd_pkg::*;
#(
    parameter int               DATA_W   = 16,
    parameter int               ADDR_W   = 16,
    parameter int               NREG     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [OP_W-1:0]   HALT_OP  = HALT_OP_DEF,
    localparam int              RAW      = $clog2(NREG)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              ir_valid,
    output logic [OP_W-1:0]   opcode,
    output logic [REG_W-1:0]  reg1,
    output logic [REG_W-1:0]  reg2,
    output logic [REG_W-1:0]  regDest,
    output logic [IMM1_W-1:0] imm1,
    output logic [IMM2_W-1:0] imm2,
    output logic [IMM3_W-1:0] imm3,
    input  logic              ex_done,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              wr_en,
    input  logic [RAW-1:0]    wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [RAW-1:0]    rdAddrA,
    input  logic [RAW-1:0]    rdAddrB,
    output logic [DATA_W-1:0] rdDataA,
    output logic [DATA_W-1:0] rdDataB,
    output logic [DATA_W-1:0] ACCData,
    output logic [DATA_W-1:0] ACCOData,
    output logic [DATA_W-1:0] SPData,
    output logic [DATA_W-1:0] RAData,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE:   state_d = run ? FETCH : IDLE;
            FETCH:  state_d = WAIT;
            WAIT: if (mem_valid) begin
                ir_d    = mem_rdata;
                state_d = DECODE;
            end
            DECODE: state_d = (opcode == HALT_OP) ? HALT : EXEC;
            EXEC: if (ex_done) begin
                pc_d    = br_valid ? br_target : pc_q + 1'b1;
                state_d = FETCH;
            end
            default: ;
        endcase
    end

    // ir only changes on WAIT->DECODE, so the fields stay stable until the next decode
    assign opcode   = ir_q[DATA_W-1 -: OP_W];
    assign reg1     = ir_q[REG1_LSB +: REG_W];
    assign reg2     = ir_q[REG2_LSB +: REG_W];
    assign regDest  = ir_q[DEST_LSB +: REG_W];
    assign imm1     = ir_q[IMM1_W-1:0];
    assign imm2     = ir_q[IMM2_W-1:0];
    assign imm3     = ir_q[IMM3_W-1:0];
    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign mem_rd   = state_q == FETCH;
    assign ir_valid = state_q == DECODE;
    assign halted   = state_q == HALT;

    fd_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
        .clk_i       (CLK),
        .rst_ni      (RST),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .rd_addr_a_i (rdAddrA),
        .rd_addr_b_i (rdAddrB),
        .rd_data_a_o (rdDataA),
        .rd_data_b_o (rdDataB),
        .acc_o       (ACCData),
        .acco_o      (ACCOData),
        .sp_o        (SPData),
        .ra_o        (RAData)
    );
endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// tb_fetch_decode_ctrl: scoreboard bench for fetch_decode_ctrl; expected fetch
// addresses and decode fields are queued when stimulus is driven.
module tb_fetch_decode_ctrl;
    logic        CLK = 0, RST = 0, run = 0;
    logic [15:0] mem_addr, mem_rdata = '0;
    logic        mem_rd, mem_valid = 0, ir_valid;
    logic [3:0]  opcode;
    logic [1:0]  reg1, reg2, regDest;
    logic [5:0]  imm1;
    logic [7:0]  imm2;
    logic [9:0]  imm3;
    logic        ex_done = 0, br_valid = 0, wr_en = 0;
    logic [15:0] br_target = '0, wr_data = '0;
    logic [1:0]  wr_addr = '0, rdAddrA = '0, rdAddrB = '0;
    logic [15:0] rdDataA, rdDataB, ACCData, ACCOData, SPData, RAData, pc;
    logic        halted;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] r1, r2, rd;
        logic [5:0] i1;
        logic [7:0] i2;
        logic [9:0] i3;
    } dec_t;

    logic [15:0] addr_q[$];
    dec_t        dec_q[$];
    logic [15:0] exp_pc;
    int          checks = 0, failures = 0;

    fetch_decode_ctrl dut (
        .CLK(CLK), .RST(RST), .run(run), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .ir_valid(ir_valid),
        .opcode(opcode), .reg1(reg1), .reg2(reg2), .regDest(regDest),
        .imm1(imm1), .imm2(imm2), .imm3(imm3), .ex_done(ex_done),
        .br_valid(br_valid), .br_target(br_target), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rdAddrA(rdAddrA), .rdAddrB(rdAddrB),
        .rdDataA(rdDataA), .rdDataB(rdDataB), .ACCData(ACCData), .ACCOData(ACCOData),
        .SPData(SPData), .RAData(RAData), .pc(pc), .halted(halted)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST = 0; run = 0; mem_valid = 0; ex_done = 0; br_valid = 0; wr_en = 0;
        repeat (2) tick();
        RST = 1;
        addr_q.delete();
        dec_q.delete();
        exp_pc = 16'h0000;
        addr_q.push_back(exp_pc);
    endtask

    // Waits for the read request, answers after lat cycles, checks the decode.
    task automatic fetch(input logic [15:0] data, input int lat);
        bit          seen = 0;
        logic [15:0] ea;
        dec_t        ed, got;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (mem_rd === 1'b1) seen = 1;
            else tick();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL fetch_timeout mem_rd=%b required 1", mem_rd);
        end
        ea = (addr_q.size() != 0) ? addr_q.pop_front() : 16'hxxxx;
        checks++;
        if (mem_addr !== ea) begin
            failures++;
            $display("FAIL fetch_addr mem_addr=%h required %h", mem_addr, ea);
        end
        tick();
        checks++;
        if (mem_rd !== 1'b0) begin
            failures++;
            $display("FAIL mem_rd_pulse mem_rd=%b required 0", mem_rd);
        end
        repeat (lat - 1) tick();
        mem_rdata = data;
        mem_valid = 1;
        ed = '{op: data[15:12], r1: data[11:10], r2: data[9:8], rd: data[7:6],
               i1: data[5:0], i2: data[7:0], i3: data[9:0]};
        dec_q.push_back(ed);
        tick();
        mem_valid = 0;
        checks++;
        if (ir_valid !== 1'b1) begin
            failures++;
            $display("FAIL ir_valid ir_valid=%b required 1", ir_valid);
        end
        ed  = dec_q.pop_front();
        got = {opcode, reg1, reg2, regDest, imm1, imm2, imm3};
        checks++;
        if (got !== ed) begin
            failures++;
            $display("FAIL decode_fields got=%h required %h", got, ed);
        end
        tick();
        checks++;
        if (ir_valid !== 1'b0) begin
            failures++;
            $display("FAIL ir_valid_pulse ir_valid=%b required 0", ir_valid);
        end
        got = {opcode, reg1, reg2, regDest, imm1, imm2, imm3};
        checks++;
        if (got !== ed) begin
            failures++;
            $display("FAIL fields_held got=%h required %h", got, ed);
        end
    endtask

    task automatic do_exec(input bit br, input logic [15:0] tgt);
        ex_done = 1; br_valid = br; br_target = tgt;
        exp_pc = br ? tgt : exp_pc + 16'd1;
        addr_q.push_back(exp_pc);
        tick();
        ex_done = 0; br_valid = 0;
        checks++;
        if (pc !== exp_pc) begin
            failures++;
            $display("FAIL exec_pc pc=%h required %h", pc, exp_pc);
        end
    endtask

    task automatic test_reset();
        RST = 0;
        #3;
        checks++;
        if ({mem_rd, ir_valid, halted, pc, ACCData, ACCOData, SPData, RAData, opcode} !== '0) begin
            failures++;
            $display("FAIL reset_state rd=%b irv=%b halt=%b pc=%h acc=%h acco=%h sp=%h ra=%h op=%h required all 0",
                     mem_rd, ir_valid, halted, pc, ACCData, ACCOData, SPData, RAData, opcode);
        end
        apply_reset();
        repeat (3) begin
            tick();
            checks++;
            if (mem_rd !== 1'b0) begin
                failures++;
                $display("FAIL idle_no_fetch mem_rd=%b required 0", mem_rd);
            end
        end
    endtask

    task automatic test_fetch_decode();
        run = 1;
        fetch(16'h1A40, 3);
    endtask

    task automatic test_branch();
        br_valid = 1; br_target = 16'h0BAD;
        repeat (2) tick();
        br_valid = 0;
        checks++;
        if (pc !== 16'h0000 || mem_rd !== 1'b0) begin
            failures++;
            $display("FAIL br_without_done pc=%h rd=%b required 0000 0", pc, mem_rd);
        end
        do_exec(0, '0);
        fetch(16'h2345, 1);
        do_exec(1, 16'h0040);
        fetch(16'h3FC1, 2);
        do_exec(1, 16'hFFFF);
        fetch(16'h4000, 1);
        do_exec(0, '0);
        fetch(16'h5555, 2);
    endtask

    task automatic test_regfile();
        logic [15:0] vals [4] = '{16'd500, 16'd100, 16'd4, 16'd256};
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; wr_addr = 2'(i); wr_data = vals[i];
            tick();
        end
        wr_en = 0;
        checks++;
        if ({ACCData, ACCOData, SPData, RAData} !== {vals[0], vals[1], vals[2], vals[3]}) begin
            failures++;
            $display("FAIL regfile_taps acc=%0d acco=%0d sp=%0d ra=%0d required 500 100 4 256",
                     ACCData, ACCOData, SPData, RAData);
        end
        rdAddrA = 2'd2; rdAddrB = 2'd3;
        wr_en = 1; wr_addr = 2'd2; wr_data = 16'd7;
        #1;
        checks++;
        if (rdDataA !== 16'd4) begin
            failures++;
            $display("FAIL read_during_write rdDataA=%0d required 4", rdDataA);
        end
        tick();
        wr_en = 0;
        checks++;
        if (rdDataA !== 16'd7 || rdDataB !== 16'd256) begin
            failures++;
            $display("FAIL read_after_write rdDataA=%0d rdDataB=%0d required 7 256", rdDataA, rdDataB);
        end
    endtask

    task automatic test_simultaneous();
        wr_en = 1; wr_addr = 2'd0; wr_data = 16'h0BEE;
        do_exec(0, '0);
        wr_en = 0;
        checks++;
        if (ACCData !== 16'h0BEE) begin
            failures++;
            $display("FAIL write_with_exec ACCData=%h required 0bee", ACCData);
        end
    endtask

    task automatic test_halt();
        fetch(16'hF000, 1);
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL halted halted=%b required 1", halted);
        end
        run = 1; mem_valid = 1; ex_done = 1; br_valid = 1; br_target = 16'h1111;
        wr_en = 1; wr_addr = 2'd0; wr_data = 16'd500;
        repeat (4) begin
            tick();
            wr_en = 0;
            checks++;
            if (pc !== exp_pc || halted !== 1'b1 || mem_rd !== 1'b0) begin
                failures++;
                $display("FAIL halt_frozen pc=%h halted=%b rd=%b required %h 1 0", pc, halted, mem_rd, exp_pc);
            end
        end
        mem_valid = 0; ex_done = 0; br_valid = 0;
        checks++;
        if (ACCData !== 16'd500) begin
            failures++;
            $display("FAIL halt_write ACCData=%0d required 500", ACCData);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [15:0] ea;
        apply_reset();
        run = 1;
        wr_en = 1; wr_addr = 2'd1; wr_data = 16'd9;
        tick();
        wr_en = 0;
        fetch(16'h1000, 1);
        do_exec(1, 16'h1234);
        ea = addr_q.pop_front();
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== ea) begin
            failures++;
            $display("FAIL branch_fetch rd=%b addr=%h required 1 %h", mem_rd, mem_addr, ea);
        end
        tick();
        mem_rdata = 16'hF000; mem_valid = 1;
        #2 RST = 0; run = 0;
        #1;
        checks++;
        if ({pc, mem_rd, ir_valid, halted, ACCOData} !== '0) begin
            failures++;
            $display("FAIL reset_in_wait pc=%h rd=%b irv=%b halt=%b acco=%h required all 0",
                     pc, mem_rd, ir_valid, halted, ACCOData);
        end
        repeat (2) tick();
        RST = 1;
        repeat (3) begin
            tick();
            checks++;
            if (mem_rd !== 1'b0 || ir_valid !== 1'b0) begin
                failures++;
                $display("FAIL stale_valid_idle rd=%b irv=%b required 0 0", mem_rd, ir_valid);
            end
        end
        mem_valid = 0;
        addr_q.delete();
        exp_pc = 16'h0000;
        addr_q.push_back(exp_pc);
        run = 1;
        fetch(16'h2000, 2);
        checks++;
        if ({ACCData, ACCOData, SPData, RAData} !== '0) begin
            failures++;
            $display("FAIL regs_after_reset acc=%h acco=%h sp=%h ra=%h required 0",
                     ACCData, ACCOData, SPData, RAData);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_decode();
        test_branch();
        test_regfile();
        test_simultaneous();
        test_halt();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_decode_ctrl.md
Name: fetch_decode_ctrl

Overview:
- Parametrised multi-cycle fetch/decode controller for the double-accumulator processor.
- Owns the PC, the instruction register, field decode and the architectural register file (ACC, ACCO, SP, RA at the default depth).
- Sequences fetch → memory wait → decode → execute-handshake with a variable-latency memory port. This replaces testbench-driven PC/IR stepping with a self-running FSM.

Parameters:
- DATA_W, 16, instruction/data width (must be ≥16).
- ADDR_W, 16, PC / memory address width.
- NREG, 4, register file depth (power of 2, ≥4); index 0=ACC, 1=ACCO, 2=SP, 3=RA.
- RESET_PC, 0, PC value after reset.
- HALT_OP, 4'hF, opcode that parks the FSM in HALT.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- run  in  1  level; leave IDLE and begin fetching.
- mem_addr  out  ADDR_W  fetch address (= pc).
- mem_rd  out  1  one-cycle read request.
- mem_rdata  in  DATA_W  read data, valid with mem_valid.
- mem_valid  in  1  read response strobe.
- ir_valid  out  1  one-cycle pulse: new instruction decoded.
- opcode  out  4  ir[DATA_W-1:DATA_W-4].
- reg1, reg2, regDest  out  2 each  ir[11:10], ir[9:8], ir[7:6].
- imm1  out  6  ir[5:0].
- imm2  out  8  ir[7:0].
- imm3  out  10  ir[9:0].
- ex_done  in  1  execute stage finished current instruction.
- br_valid  in  1  redirect PC (sampled only with ex_done).
- br_target  in  ADDR_W  redirect address.
- wr_en  in  1  register file write.
- wr_addr  in  log2(NREG)  write index.
- wr_data  in  DATA_W  write data.
- rdAddrA, rdAddrB  in  log2(NREG)  read indices.
- rdDataA, rdDataB  out  DATA_W  combinational reads.
- ACCData, ACCOData, SPData, RAData  out  DATA_W  registers 0..3.
- pc  out  ADDR_W  current PC.
- halted  out  1  high in HALT.

Behaviour:
- Reset values (RST low, async): state=IDLE, pc=RESET_PC, ir=0, all registers 0, mem_rd=0, ir_valid=0, halted=0.
- IDLE: run=1 → FETCH. Any mem_valid arriving here is ignored.
- FETCH: mem_rd=1 for exactly one cycle, mem_addr=pc → WAIT.
- WAIT: mem_valid=1 → ir<=mem_rdata, go to DECODE. Same-cycle response is not possible; minimum fetch latency is 2 cycles from FETCH entry to DECODE.
- DECODE:
  - ir_valid=1 for one cycle.
  - Decode fields are registered from ir and held stable until the next DECODE.
  - opcode==HALT_OP → HALT, otherwise → EXEC.
- EXEC:
  - Waits for ex_done.
  - On ex_done: pc<=br_valid ? br_target : pc+1, then → FETCH.
  - br_valid without ex_done is ignored.
- PC arithmetic is modulo 2^ADDR_W: pc=all-ones increments to 0.
- HALT: halted=1, PC frozen; exits only by reset.
- Deasserting run is sampled only in IDLE; an instruction in flight always completes.
- Register file:
  - Write on rising edge when wr_en, in any FSM state, including HALT.
  - Reads are combinational from the stored value; no write-through bypass, so a read of the register being written returns the old value that cycle.
  - wr_addr ≥ NREG is impossible by width. All NREG entries are writable (no zero register).
- Simultaneous wr_en and ex_done: both take effect independently.
- Reset mid-WAIT: the pending response is discarded and the next fetch uses RESET_PC.
- Fields narrower than the IR overlap by design (imm2/imm3 share bits with regDest/reg2); downstream selects by opcode.

Decomposition:
- Package fd_pkg holds:
  - state enum: IDLE, FETCH, WAIT, DECODE, EXEC, HALT.
  - field bit-position constants.
  - ACC_IDX=0, ACCO_IDX=1, SP_IDX=2, RA_IDX=3.
  - default HALT_OP.
- One sub-module, fd_regfile: NREG×DATA_W, 1 write port, 2 read ports, plus fixed taps for indices 0–3.

Test Plan:
- Reset then run=1, memory responds 3 cycles after mem_rd with 16'h1A40 → mem_addr=0, ir_valid pulse, reg1=2, reg2=2, regDest=1, imm1=6'h00, opcode=1.
- ex_done with br_valid=0 at pc=0 → next mem_addr=1; ex_done with br_valid=1, br_target=16'h0040 → next mem_addr=16'h0040.
- pc preloaded via branch to 16'hFFFF, ex_done without branch → next fetch at 0.
- Fetch 16'hF000 → DECODE then HALT; halted=1; further mem_valid/ex_done leave pc unchanged. A register write of 500 to ACC still lands (ACCData=500).
- Register file sequence: write ACC=500, ACCO=100, SP=4, RA=256 → ACCData=500, ACCOData=100, SPData=4, RAData=256. Read of SP in the same cycle as a write of 7 to SP returns 4, then 7 the next cycle.
- Assert RST in WAIT, release, run=1; stale mem_valid during IDLE → ignored; first fetch at RESET_PC, all registers 0.
